keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- Input-side counterpart of the multiplexed 7-segment display driver: scans a 4x4 active-low matrix keypad (rows driven, columns read) and debounces key presses.
- Emits one key event per press and keeps a 6-digit nibble history buffer. The buffer's 24-bit format (6 x 4-bit digits, first digit at [23:20]) connects directly to the display driver's data input.
- Runs on the 1 kHz scan clock.

Parameters:
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release. Legal range 1..15.

Ports:
- clk_1khz, input, 1: scan clock, 1 kHz.
- rst, input, 1: one clock; reset is synchronous and active-high.
- col_in, input, 4: keypad columns, active-low, pulled up, asynchronous to clk_1khz.
- clr, input, 1: synchronous clear of the digit buffer.
- row_out, output, 4: row drive, active-low one-hot.
- key_code, output, 4: last accepted key, computed as row*4 + col.
- key_valid, output, 1: one-cycle pulse when a press is accepted.
- key_down, output, 1: level, high from press acceptance to release acceptance.
- digits, output, 24: last six accepted codes; newest at [3:0], oldest at [23:20].

Behaviour:
- Reset (rst=1 at a clk_1khz edge):
  - row_out=4'b1110; key_code=0; key_valid=0; key_down=0; digits=0.
  - Synchronizer flops=4'hF; row/phase counters=0; FSM=IDLE; debounce count=0.
  - Reset mid-press or mid-debounce discards all progress and produces no key_valid.
- Synchronizer: col_in passes through two flops before use.
- Scan timing:
  - 2-bit row counter r and 2-bit phase counter p; p increments every cycle, and r increments when p wraps.
  - row_out = ~(1<<r), held for 4 cycles per row.
  - Synchronized columns are sampled at p==3 of each row.
  - A full scan is 16 cycles. Scan end is the r==3, p==3 sample.
- Scan result, evaluated at scan end:
  - Exactly one column low across all four rows gives SINGLE(code).
  - Zero lows gives NONE.
  - Two or more lows (multi-key or ghosting) also give NONE.
- FSM transitions, taken only at scan end. State, count and outputs update on the cycle following the scan-end sample.
  - IDLE: SINGLE(K) sets cand=K, cnt=1 and goes to DEBOUNCE. If DEBOUNCE_SCANS==1, accept immediately instead. NONE stays in IDLE.
  - DEBOUNCE: SINGLE(cand) increments cnt; when cnt reaches DEBOUNCE_SCANS, accept. SINGLE(other) sets cand=other, cnt=1. NONE returns to IDLE.
  - Accept: key_code=cand, key_valid=1 for exactly one cycle, key_down=1, digits={digits[19:0],cand}, go to PRESSED.
  - PRESSED: SINGLE (any key) stays; there is no auto-repeat and no second event. NONE sets cnt=1 and goes to RELEASE (immediate release if DEBOUNCE_SCANS==1).
  - RELEASE: NONE increments cnt; at DEBOUNCE_SCANS, key_down=0 and go to IDLE. SINGLE returns to PRESSED with cnt=0.
- Press latency: key_valid rises 1 cycle after the DEBOUNCE_SCANS-th consecutive matching scan end.
- clr: sets digits=0 on the next cycle.
  - clr coincident with accept gives digits={20'h0,cand}, and key_valid still pulses.
  - clr does not affect key_code, key_down or the FSM.
- key_code holds its value until the next accept; it is not cleared on release.
- Counters wrap freely; no overflow condition exists on r or p.

Decomposition:
- keypad_pkg holds:
  - FSM state encodings: IDLE=0, DEBOUNCE=1, PRESSED=2, RELEASE=3.
  - ROWS=4, COLS=4, PHASES=4, SAMPLE_PHASE=3.
  - The NONE/SINGLE result encoding.
- col_sync: a 4-bit two-flop synchronizer with synchronous reset to 4'hF. This is the one sub-module.
- Scan, debounce FSM and digit buffer live in keypad_scan.

Test Plan:
- Reset: assert rst for 3 cycles, then release → row_out=1110, all outputs 0, row_out cycles 1110→1101→1011→0111 every 4 cycles.
- Clean press of row 2 / col 1 (col_in=4'b1101 only while row_out=1011), held 200 cycles → exactly one key_valid, key_code=9, digits=24'h000009, key_down high; key_down low 4 scans after release.
- Bouncy press: col toggles on alternating scans for 3 scans, then stable → exactly one key_valid, occurring 4 stable scans after bouncing stops; no event during the bounce.
- Six clean presses of codes 1,9,0,9,0,5 → six key_valid pulses, digits=24'h190905.
- Two keys (code 0 and code 5) held together for 10 scans → no key_valid, key_down stays 0.
- Reset mid-debounce (rst after 2 matching scans) → no key_valid. clr coincident with accept of code 7, with digits=24'h123456 → digits=24'h000007.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner.
//   - FSM state encoding for the press/release debouncer
//   - scan geometry (rows, columns, phases per row, sampling phase)
//   - per-scan result type (NONE / SINGLE with key code)
//   - helpers that inspect one row's active-low column sample
package keypad_pkg;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int PHASES = 4;
  localparam logic [1:0] SAMPLE_PHASE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  typedef enum logic {
    SCAN_NONE   = 1'b0,
    SCAN_SINGLE = 1'b1
  } scan_kind_t;

  typedef struct packed {
    scan_kind_t kind;
    logic [3:0] code;
  } scan_result_t;

  // Number of active-low (pressed) columns in one row sample.
  function automatic logic [2:0] count_lows(input logic [3:0] cols);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < COLS; i++) begin
      if (!cols[i]) n = n + 3'd1;
    end
    return n;
  endfunction

  // Index of the lowest-numbered low column; only meaningful when one is low.
  function automatic logic [1:0] first_low(input logic [3:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!cols[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/col_sync.sv
// Two-flop synchronizer for the keypad column inputs.
//   clk_1khz : scan clock
//   rst      : synchronous active-high reset, flops go to 4'hF (no key)
//   col_in   : raw active-low columns, asynchronous to clk_1khz
//   cols     : synchronized columns, two cycles behind col_in
module col_sync (
  input  logic       clk_1khz,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] cols
);

  logic [3:0] meta_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value; blocking here would collapse the two stages.
  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      meta_q <= 4'hF;
      cols   <= 4'hF;
    end else begin
      meta_q <= col_in;
      cols   <= meta_q;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with debounce and a 6-digit history.
//   clk_1khz  : 1 kHz scan clock
//   rst       : synchronous active-high reset
//   col_in    : keypad columns, active-low, asynchronous
//   clr       : synchronous clear of the digit history
//   row_out   : active-low one-hot row drive, 4 cycles per row
//   key_code  : last accepted key (row*4 + col), held until the next accept
//   key_valid : one-cycle pulse on press acceptance
//   key_down  : high from press acceptance until release acceptance
//   digits    : last six accepted codes, newest in [3:0]
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk_1khz,
  input  logic        rst,
  input  logic [3:0]  col_in,
  input  logic        clr,
  output logic [3:0]  row_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_down,
  output logic [23:0] digits
);

  localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

  logic [3:0] col_s;

  col_sync u_col_sync (
    .clk_1khz (clk_1khz),
    .rst      (rst),
    .col_in   (col_in),
    .cols     (col_s)
  );

  // ---------------------------------------------------------------- scan timing
  logic [1:0] row_q;
  logic [1:0] phase_q;
  logic       sample;
  logic       scan_end;

  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      row_q   <= 2'd0;
      phase_q <= 2'd0;
    end else begin
      phase_q <= phase_q + 2'd1;
      if (phase_q == 2'(PHASES - 1)) row_q <= row_q + 2'd1;
    end
  end

  assign row_out  = ~(4'b0001 << row_q);
  assign sample   = (phase_q == SAMPLE_PHASE);
  assign scan_end = sample && (row_q == 2'(ROWS - 1));

  // ------------------------------------------------------- scan accumulation
  // acc_lows saturates at 2: anything beyond one low key is already "NONE".
  logic [1:0]   acc_lows;
  logic [3:0]   acc_code;
  logic [2:0]   row_lows;
  logic [2:0]   sum_lows;
  logic [1:0]   total_lows;
  logic [3:0]   merged_code;
  scan_result_t scan_res;

  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise an uncovered path infers a latch.
  always_comb begin
    row_lows    = count_lows(col_s);
    sum_lows    = {1'b0, acc_lows} + row_lows;
    total_lows  = (sum_lows >= 3'd2) ? 2'd2 : sum_lows[1:0];
    merged_code = acc_code;
    if (acc_lows == 2'd0 && row_lows == 3'd1) merged_code = {row_q, first_low(col_s)};
    scan_res.kind = (total_lows == 2'd1) ? SCAN_SINGLE : SCAN_NONE;
    scan_res.code = merged_code;
  end

  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      acc_lows <= 2'd0;
      acc_code <= 4'd0;
    end else if (sample) begin
      if (scan_end) begin
        acc_lows <= 2'd0;
        acc_code <= 4'd0;
      end else begin
        acc_lows <= total_lows;
        acc_code <= merged_code;
      end
    end
  end

  // ------------------------------------------------------------ debounce FSM
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cand_q, cand_d;
  logic       accept;

  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      cand_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (scan_end) begin
      unique case (state_q)
        ST_IDLE: begin
          if (scan_res.kind == SCAN_SINGLE) begin
            cand_d = scan_res.code;
            if (DB == 4'd1) begin
              accept  = 1'b1;
              cnt_d   = 4'd0;
              state_d = ST_PRESSED;
            end else begin
              cnt_d   = 4'd1;
              state_d = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (scan_res.kind == SCAN_NONE) begin
            cnt_d   = 4'd0;
            state_d = ST_IDLE;
          end else if (scan_res.code != cand_q) begin
            cand_d = scan_res.code;
            cnt_d  = 4'd1;
          end else if (cnt_q + 4'd1 == DB) begin
            accept  = 1'b1;
            cnt_d   = 4'd0;
            state_d = ST_PRESSED;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_PRESSED: begin
          if (scan_res.kind == SCAN_NONE) begin
            if (DB == 4'd1) begin
              cnt_d   = 4'd0;
              state_d = ST_IDLE;
            end else begin
              cnt_d   = 4'd1;
              state_d = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (scan_res.kind == SCAN_SINGLE) begin
            cnt_d   = 4'd0;
            state_d = ST_PRESSED;
          end else if (cnt_q + 4'd1 == DB) begin
            cnt_d   = 4'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Held level follows the FSM directly: down while pressed or releasing.
  always_comb begin
    key_down = (state_q == ST_PRESSED) || (state_q == ST_RELEASE);
  end

  // ------------------------------------------------------ event and history
  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      digits    <= 24'h0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= cand_d;
        // A clear in the same cycle as an accept keeps only the new code.
        digits   <= clr ? {20'h0, cand_d} : {digits[19:0], cand_d};
      end else if (clr) begin
        digits <= 24'h0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed self-checking bench for keypad_scan (DEBOUNCE_SCANS = 4).
// A keypad model drives col_in from row_out and a 16-bit pressed-key mask.
// All key changes happen on scan boundaries (multiples of 16 cycles after
// reset release), so press latency is exactly 64 cycles.
module tb_keypad_scan;

  logic        clk_1khz = 1'b0;
  logic        rst      = 1'b1;
  logic        clr      = 1'b0;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [23:0] digits;

  logic [15:0] pressed = 16'h0;

  int errors = 0;
  int checks = 0;
  int vcount = 0;
  int base   = 0;

  keypad_scan #(.DEBOUNCE_SCANS(4)) dut (
    .clk_1khz  (clk_1khz),
    .rst       (rst),
    .col_in    (col_in),
    .clr       (clr),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down),
    .digits    (digits)
  );

  always #5 clk_1khz = ~clk_1khz;

  // Keypad model: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && pressed[r*4+c]) col_in[c] = 1'b0;
  end

  always @(negedge clk_1khz) if (key_valid === 1'b1) vcount++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_1khz);
    #1;
  endtask

  task automatic press_release(input int code);
    pressed = 16'h0;
    pressed[code] = 1'b1;
    step(16 * 6);
    pressed = 16'h0;
    step(16 * 5);
  endtask

  initial begin
    // Reset for three cycles.
    repeat (3) @(posedge clk_1khz);
    #1;
    check("rst_row_out", 32'(row_out), 32'hE);
    check("rst_key_code", 32'(key_code), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_down", 32'(key_down), 32'h0);
    check("rst_digits", 32'(digits), 32'h0);
    rst = 1'b0;

    // Row rotation, 4 cycles per row.
    check("row0", 32'(row_out), 32'hE);
    step(4); check("row1", 32'(row_out), 32'hD);
    step(4); check("row2", 32'(row_out), 32'hB);
    step(4); check("row3", 32'(row_out), 32'h7);
    step(4); check("row_wrap", 32'(row_out), 32'hE);

    // Clean press of row 2 / col 1 -> code 9, exact latency of 64 cycles.
    base = vcount;
    pressed = 16'h0; pressed[9] = 1'b1;
    step(63);
    check("clean_pre_valid", 32'(key_valid), 32'h0);
    check("clean_pre_down", 32'(key_down), 32'h0);
    step(1);
    check("clean_valid", 32'(key_valid), 32'h1);
    check("clean_code", 32'(key_code), 32'h9);
    check("clean_digits", digits, 32'h000009);
    check("clean_down", 32'(key_down), 32'h1);
    step(1);
    check("clean_pulse_width", 32'(key_valid), 32'h0);
    step(15 + 16 * 8);
    check("clean_one_event", 32'(vcount - base), 32'h1);
    check("clean_held_down", 32'(key_down), 32'h1);
    // Release: key_down drops after the 4th empty scan.
    pressed = 16'h0;
    step(63);
    check("release_pre", 32'(key_down), 32'h1);
    step(1);
    check("release_done", 32'(key_down), 32'h0);
    check("release_code_held", 32'(key_code), 32'h9);

    // Bouncy press of code 6: on/off/on/off, then stable.
    base = vcount;
    for (int b = 0; b < 4; b++) begin
      pressed = (b % 2 == 0) ? 16'h0040 : 16'h0000;
      step(16);
    end
    check("bounce_no_event", 32'(vcount - base), 32'h0);
    check("bounce_not_down", 32'(key_down), 32'h0);
    pressed = 16'h0040;
    step(63);
    check("bounce_pre_valid", 32'(vcount - base), 32'h0);
    step(1);
    check("bounce_valid", 32'(key_valid), 32'h1);
    check("bounce_code", 32'(key_code), 32'h6);
    step(15 + 16 * 2);
    check("bounce_one_event", 32'(vcount - base), 32'h1);
    pressed = 16'h0;
    step(16 * 5);

    // Six presses shift the history to 190905.
    base = vcount;
    press_release(1); press_release(9); press_release(0);
    press_release(9); press_release(0); press_release(5);
    check("six_events", 32'(vcount - base), 32'h6);
    check("six_digits", digits, 32'h190905);
    check("six_code", 32'(key_code), 32'h5);

    // Two keys at once (codes 0 and 5): no event, not down.
    base = vcount;
    pressed = 16'h0021;
    step(16 * 10);
    check("multi_no_event", 32'(vcount - base), 32'h0);
    check("multi_not_down", 32'(key_down), 32'h0);
    check("multi_code_held", 32'(key_code), 32'h5);
    pressed = 16'h0;
    step(16 * 2);

    // Reset after two matching scans of code 3: progress is discarded.
    base = vcount;
    pressed = 16'h0008;
    step(32);
    pressed = 16'h0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(16 * 6);
    check("midrst_no_event", 32'(vcount - base), 32'h0);
    check("midrst_not_down", 32'(key_down), 32'h0);
    check("midrst_digits", digits, 32'h0);

    // Build 123456, then clr coincident with accept of code 7.
    press_release(1); press_release(2); press_release(3);
    press_release(4); press_release(5); press_release(6);
    check("hist_digits", digits, 32'h123456);
    pressed = 16'h0; pressed[7] = 1'b1;
    step(63);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clracc_valid", 32'(key_valid), 32'h1);
    check("clracc_digits", digits, 32'h000007);
    check("clracc_code", 32'(key_code), 32'h7);
    // Standalone clr: digits cleared, key state untouched.
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_digits", digits, 32'h0);
    check("clr_code", 32'(key_code), 32'h7);
    check("clr_down", 32'(key_down), 32'h1);
    step(14);
    pressed = 16'h0;
    step(16 * 5);
    check("final_not_down", 32'(key_down), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
